// File: rtl/my_ram8.sv
// Eight-word register file with a one-hot write-enable decode and a
// combinational read mux; building block for the larger RAM levels.
module my_ram8 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic [2:0]       address,
   output logic [WIDTH-1:0] out
);

   logic [7:0]       we_s;
   logic [WIDTH-1:0] word_d [8];
   logic [WIDTH-1:0] word_q [8];

   // Write-enable demux: load steered to exactly one word, or none.
   always_comb begin
      we_s = 8'h00;
      if (load) begin
         case (address)
            3'd0:    we_s = 8'b0000_0001;
            3'd1:    we_s = 8'b0000_0010;
            3'd2:    we_s = 8'b0000_0100;
            3'd3:    we_s = 8'b0000_1000;
            3'd4:    we_s = 8'b0001_0000;
            3'd5:    we_s = 8'b0010_0000;
            3'd6:    we_s = 8'b0100_0000;
            3'd7:    we_s = 8'b1000_0000;
            default: we_s = 8'h00;
         endcase
      end else begin
         we_s = 8'h00;
      end
   end

   // Next-state: enabled word takes the write data, others hold.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         word_d[i] = word_q[i];
         if (we_s[i]) begin
            word_d[i] = in;
         end else begin
            word_d[i] = word_q[i];
         end
      end
   end

   // Storage; reset clears every word immediately, dropping any pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            word_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            word_q[i] <= word_d[i];
         end
      end
   end

   // Read mux: no latency, no bypass of the word being written.
   always_comb begin
      out = word_q[address];
   end

endmodule

// File: tb/tb_my_ram8.sv
// Directed and randomised self-checking bench for my_ram8.
module tb_my_ram8;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_s;
   logic        load_s;
   logic [2:0]  address_s;
   logic [15:0] out_s;

   int pass_cnt;
   int total_cnt;

   my_ram8 #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in_s),
      .load    (load_s),
      .address (address_s),
      .out     (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load_s = 1'b1;
      in_s = 16'hDEAD;
      address_s = 3'd0;
      #2;
      for (int a = 0; a < 8; a++) begin
         address_s = a[2:0];
         #1;
         total_cnt++;
         if (out_s !== 16'h0000)
            $display("FAIL reset_read addr=%0d got=%h exp=0000", a, out_s);
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (out_s !== 16'h0000)
         $display("FAIL reset_ignores_load got=%h exp=0000", out_s);
      else pass_cnt++;
      load_s = 1'b0;
      rst_n = 1'b1;
      tick();
      load_s = 1'b1;
      address_s = 3'd3;
      in_s = 16'hFFFF;
      tick();
      load_s = 1'b0;
      total_cnt++;
      if (out_s !== 16'hFFFF)
         $display("FAIL reset_prewrite got=%h exp=ffff", out_s);
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (out_s !== 16'h0000)
         $display("FAIL reset_async_clear got=%h exp=0000", out_s);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_all();
      for (int k = 0; k < 8; k++) begin
         load_s = 1'b1;
         address_s = k[2:0];
         in_s = 16'h1000 + k[15:0];
         tick();
      end
      load_s = 1'b0;
      for (int k = 0; k < 8; k++) begin
         address_s = k[2:0];
         #1;
         total_cnt++;
         if (out_s !== 16'h1000 + k[15:0])
            $display("FAIL write_all addr=%0d got=%h exp=%h", k, out_s, 16'h1000 + k[15:0]);
         else pass_cnt++;
      end
      tick();
   endtask

   task automatic test_isolation();
      load_s = 1'b1;
      address_s = 3'd5;
      in_s = 16'hAAAA;
      tick();
      load_s = 1'b0;
      address_s = 3'd4;
      #1;
      total_cnt++;
      if (out_s !== 16'h1004) $display("FAIL iso_addr4 got=%h exp=1004", out_s);
      else pass_cnt++;
      address_s = 3'd6;
      #1;
      total_cnt++;
      if (out_s !== 16'h1006) $display("FAIL iso_addr6 got=%h exp=1006", out_s);
      else pass_cnt++;
      address_s = 3'd5;
      in_s = 16'h5555;
      for (int n = 0; n < 3; n++) tick();
      total_cnt++;
      if (out_s !== 16'hAAAA) $display("FAIL hold_addr5 got=%h exp=aaaa", out_s);
      else pass_cnt++;
   endtask

   task automatic test_read_during_write();
      load_s = 1'b1;
      address_s = 3'd2;
      in_s = 16'h1234;
      tick();
      in_s = 16'hBEEF;
      #1;
      total_cnt++;
      if (out_s !== 16'h1234) $display("FAIL rdw_before got=%h exp=1234", out_s);
      else pass_cnt++;
      tick();
      load_s = 1'b0;
      total_cnt++;
      if (out_s !== 16'hBEEF) $display("FAIL rdw_after got=%h exp=beef", out_s);
      else pass_cnt++;
   endtask

   task automatic test_comb_read();
      logic [15:0] exp_tbl [8];
      exp_tbl = '{16'h1000, 16'h1001, 16'hBEEF, 16'h1003,
                  16'h1004, 16'hAAAA, 16'h1006, 16'h1007};
      load_s = 1'b0;
      tick();
      for (int a = 0; a < 8; a++) begin
         address_s = a[2:0];
         #1;
         total_cnt++;
         if (out_s !== exp_tbl[a])
            $display("FAIL comb_read addr=%0d got=%h exp=%h", a, out_s, exp_tbl[a]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [15:0] ref_mem [8];
      int          errs;
      errs = 0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int a = 0; a < 8; a++) ref_mem[a] = 16'h0000;
      tick();
      for (int c = 0; c < 1000; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            #1;
            for (int a = 0; a < 8; a++) ref_mem[a] = 16'h0000;
            rst_n = 1'b1;
         end
         load_s = ($urandom_range(0, 1) == 1);
         address_s = 3'($urandom_range(0, 7));
         in_s = 16'($urandom);
         #1;
         total_cnt++;
         if (out_s !== ref_mem[address_s]) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random_read cyc=%0d addr=%0d got=%h exp=%h",
                        c, address_s, out_s, ref_mem[address_s]);
         end else pass_cnt++;
         @(posedge clk);
         if (load_s) ref_mem[address_s] = in_s;
         #1;
      end
      load_s = 1'b0;
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      rst_n = 1'b1;
      load_s = 1'b0;
      in_s = 16'h0000;
      address_s = 3'd0;
      test_reset();
      test_write_all();
      test_isolation();
      test_read_during_write();
      test_comb_read();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
